// File: rtl/reg_rename_file.sv
// Architectural register file with a per-register rename table (busy bit and producer ROB tag).
// Supplies issue-time operands and absorbs register writes from the ROB commit port.
module reg_rename_file #(
    parameter int ROB_W = 4,
    parameter int XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             is_sgn,
    input  logic [4:0]       is_rs1,
    input  logic [4:0]       is_rs2,
    input  logic [4:0]       is_rd,
    input  logic [ROB_W-1:0] is_rob_name,
    output logic             rs1_rdy,
    output logic [XLEN-1:0]  rs1_val,
    output logic [ROB_W-1:0] rs1_tag,
    output logic             rs2_rdy,
    output logic [XLEN-1:0]  rs2_val,
    output logic [ROB_W-1:0] rs2_tag,
    output logic [ROB_W-1:0] rob_ord1,
    output logic [ROB_W-1:0] rob_ord2,
    input  logic             rob_rdy1,
    input  logic [XLEN-1:0]  rob_val1,
    input  logic             rob_rdy2,
    input  logic [XLEN-1:0]  rob_val2,
    input  logic             commit_sgn,
    input  logic [4:0]       commit_dest,
    input  logic [XLEN-1:0]  commit_value,
    input  logic [ROB_W-1:0] commit_rob_name
);

    // Handshake: is_sgn and commit_sgn are single-cycle valid strobes with no
    // ready return; each is consumed on the rising edge where rdy=1 and rst=0.

    logic [XLEN-1:0]  val_q  [32];
    logic             busy_q [32];
    logic [ROB_W-1:0] tag_q  [32];

    logic             busy1;
    logic             busy2;
    logic [ROB_W-1:0] tag1;
    logic [ROB_W-1:0] tag2;
    logic [XLEN-1:0]  arch1;
    logic [XLEN-1:0]  arch2;

    assign busy1 = busy_q[is_rs1];
    assign busy2 = busy_q[is_rs2];
    assign tag1  = tag_q[is_rs1];
    assign tag2  = tag_q[is_rs2];
    assign arch1 = val_q[is_rs1];
    assign arch2 = val_q[is_rs2];

    assign rob_ord1 = tag1;
    assign rob_ord2 = tag2;
    assign rs1_tag  = tag1;
    assign rs2_tag  = tag2;

    // Reads see the mapping from before this cycle's rename, so rs==rd gets the old producer.
    always_comb begin
        rs1_rdy = 1'b0;
        rs1_val = '0;
        if (is_rs1 == 5'd0) begin
            rs1_rdy = 1'b1;
        end else if (!busy1) begin
            rs1_rdy = 1'b1;
            rs1_val = arch1;
        end else if (commit_sgn && (commit_rob_name == tag1)) begin
            rs1_rdy = 1'b1;
            rs1_val = commit_value;
        end else if (rob_rdy1) begin
            rs1_rdy = 1'b1;
            rs1_val = rob_val1;
        end
    end

    always_comb begin
        rs2_rdy = 1'b0;
        rs2_val = '0;
        if (is_rs2 == 5'd0) begin
            rs2_rdy = 1'b1;
        end else if (!busy2) begin
            rs2_rdy = 1'b1;
            rs2_val = arch2;
        end else if (commit_sgn && (commit_rob_name == tag2)) begin
            rs2_rdy = 1'b1;
            rs2_val = commit_value;
        end else if (rob_rdy2) begin
            rs2_rdy = 1'b1;
            rs2_val = rob_val2;
        end
    end

    // Later assignments win: rename overrides commit busy-clear, flush overrides both.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                val_q[i]  <= '0;
                busy_q[i] <= 1'b0;
                tag_q[i]  <= '0;
            end
        end else if (rdy) begin
            for (int i = 1; i < 32; i++) begin
                if (commit_sgn && (commit_dest == 5'(i))) begin
                    val_q[i] <= commit_value;
                    if (tag_q[i] == commit_rob_name) begin
                        busy_q[i] <= 1'b0;
                    end
                end
                if (is_sgn && (is_rd == 5'(i))) begin
                    busy_q[i] <= 1'b1;
                    tag_q[i]  <= is_rob_name;
                end
                if (flush) begin
                    busy_q[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_rename_file.sv
// Directed bench for reg_rename_file: operand sourcing priority, rename/commit
// interaction, flush, enable hold, x0 handling and mid-operation reset.
module tb_reg_rename_file;

    localparam int ROB_W = 4;
    localparam int XLEN  = 32;

    logic             clk;
    logic             rst;
    logic             rdy;
    logic             flush;
    logic             is_sgn;
    logic [4:0]       is_rs1;
    logic [4:0]       is_rs2;
    logic [4:0]       is_rd;
    logic [ROB_W-1:0] is_rob_name;
    logic             rs1_rdy;
    logic [XLEN-1:0]  rs1_val;
    logic [ROB_W-1:0] rs1_tag;
    logic             rs2_rdy;
    logic [XLEN-1:0]  rs2_val;
    logic [ROB_W-1:0] rs2_tag;
    logic [ROB_W-1:0] rob_ord1;
    logic [ROB_W-1:0] rob_ord2;
    logic             rob_rdy1;
    logic [XLEN-1:0]  rob_val1;
    logic             rob_rdy2;
    logic [XLEN-1:0]  rob_val2;
    logic             commit_sgn;
    logic [4:0]       commit_dest;
    logic [XLEN-1:0]  commit_value;
    logic [ROB_W-1:0] commit_rob_name;

    int checks   = 0;
    int failures = 0;

    reg_rename_file #(.ROB_W(ROB_W), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .is_sgn(is_sgn), .is_rs1(is_rs1), .is_rs2(is_rs2), .is_rd(is_rd),
        .is_rob_name(is_rob_name),
        .rs1_rdy(rs1_rdy), .rs1_val(rs1_val), .rs1_tag(rs1_tag),
        .rs2_rdy(rs2_rdy), .rs2_val(rs2_val), .rs2_tag(rs2_tag),
        .rob_ord1(rob_ord1), .rob_ord2(rob_ord2),
        .rob_rdy1(rob_rdy1), .rob_val1(rob_val1),
        .rob_rdy2(rob_rdy2), .rob_val2(rob_val2),
        .commit_sgn(commit_sgn), .commit_dest(commit_dest),
        .commit_value(commit_value), .commit_rob_name(commit_rob_name)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks: inputs change 1ns after the rising edge, checks run 1ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rdy = 1'b1; flush = 1'b0; is_sgn = 1'b0; is_rs1 = '0; is_rs2 = '0;
        is_rd = '0; is_rob_name = '0; rob_rdy1 = 1'b0; rob_val1 = '0;
        rob_rdy2 = 1'b0; rob_val2 = '0; commit_sgn = 1'b0; commit_dest = '0;
        commit_value = '0; commit_rob_name = '0;
    endtask

    task automatic do_rename(input logic [4:0] rd, input logic [ROB_W-1:0] rob);
        is_sgn = 1'b1; is_rd = rd; is_rob_name = rob;
    endtask

    task automatic do_commit(input logic [4:0] rd, input logic [ROB_W-1:0] rob, input logic [XLEN-1:0] v);
        commit_sgn = 1'b1; commit_dest = rd; commit_rob_name = rob; commit_value = v;
    endtask

    task automatic test_reset();
        idle(); rst = 1'b1;
        tick(); tick();
        rst = 1'b0; is_rs1 = 5'd5; is_rs2 = 5'd0; #1;
        checks++; if (rs1_rdy !== 1'b1) begin failures++; $display("FAIL reset_rs1_rdy got=%0h exp=1", rs1_rdy); end
        checks++; if (rs1_val !== 32'h0) begin failures++; $display("FAIL reset_rs1_val got=%0h exp=0", rs1_val); end
        checks++; if (rs2_rdy !== 1'b1) begin failures++; $display("FAIL reset_rs2_rdy got=%0h exp=1", rs2_rdy); end
        checks++; if (rs2_val !== 32'h0) begin failures++; $display("FAIL reset_rs2_val got=%0h exp=0", rs2_val); end
        checks++; if (rob_ord1 !== 4'h0) begin failures++; $display("FAIL reset_ord1 got=%0h exp=0", rob_ord1); end
    endtask

    task automatic test_rename_rob();
        tick(); idle();
        do_rename(5'd3, 4'd2); is_rs1 = 5'd3; #1;
        checks++; if (rs1_rdy !== 1'b1 || rs1_val !== 32'h0) begin failures++; $display("FAIL rs_eq_rd_old got=%0h/%0h exp=1/0", rs1_rdy, rs1_val); end
        tick(); idle();
        is_rs1 = 5'd3; is_rs2 = 5'd3; #1;
        checks++; if (rs1_rdy !== 1'b0) begin failures++; $display("FAIL busy_rs1_rdy got=%0h exp=0", rs1_rdy); end
        checks++; if (rs1_tag !== 4'd2) begin failures++; $display("FAIL busy_rs1_tag got=%0h exp=2", rs1_tag); end
        checks++; if (rob_ord1 !== 4'd2) begin failures++; $display("FAIL busy_ord1 got=%0h exp=2", rob_ord1); end
        checks++; if (rs1_val !== 32'h0) begin failures++; $display("FAIL busy_rs1_val got=%0h exp=0", rs1_val); end
        checks++; if (rs2_rdy !== 1'b0 || rs2_tag !== 4'd2 || rob_ord2 !== 4'd2) begin failures++; $display("FAIL busy_rs2 got=%0h/%0h/%0h exp=0/2/2", rs2_rdy, rs2_tag, rob_ord2); end
        rob_rdy1 = 1'b1; rob_val1 = 32'hAB; rob_rdy2 = 1'b1; rob_val2 = 32'hCD; #1;
        checks++; if (rs1_rdy !== 1'b1 || rs1_val !== 32'hAB) begin failures++; $display("FAIL rob_fwd1 got=%0h/%0h exp=1/ab", rs1_rdy, rs1_val); end
        checks++; if (rs2_rdy !== 1'b1 || rs2_val !== 32'hCD) begin failures++; $display("FAIL rob_fwd2 got=%0h/%0h exp=1/cd", rs2_rdy, rs2_val); end
    endtask

    task automatic test_commit_bypass();
        tick(); idle();
        do_commit(5'd3, 4'd2, 32'h55); is_rs1 = 5'd3;
        rob_rdy1 = 1'b1; rob_val1 = 32'h99; #1;
        checks++; if (rs1_rdy !== 1'b1 || rs1_val !== 32'h55) begin failures++; $display("FAIL commit_bypass got=%0h/%0h exp=1/55", rs1_rdy, rs1_val); end
        tick(); idle();
        is_rs1 = 5'd3; #1;
        checks++; if (rs1_rdy !== 1'b1 || rs1_val !== 32'h55) begin failures++; $display("FAIL commit_arch got=%0h/%0h exp=1/55", rs1_rdy, rs1_val); end
    endtask

    task automatic test_newer_rename();
        tick(); idle(); do_rename(5'd4, 4'd1);
        tick(); idle(); do_rename(5'd4, 4'd5);
        tick(); idle();
        do_commit(5'd4, 4'd1, 32'h7); is_rs1 = 5'd4; #1;
        checks++; if (rs1_rdy !== 1'b0 || rs1_tag !== 4'd5) begin failures++; $display("FAIL stale_commit_read got=%0h/%0h exp=0/5", rs1_rdy, rs1_tag); end
        tick(); idle();
        is_rs1 = 5'd4; #1;
        checks++; if (rs1_rdy !== 1'b0 || rs1_tag !== 4'd5) begin failures++; $display("FAIL newer_kept_busy got=%0h/%0h exp=0/5", rs1_rdy, rs1_tag); end
        do_commit(5'd4, 4'd5, 32'h9); do_rename(5'd4, 4'd6); #1;
        checks++; if (rs1_rdy !== 1'b1 || rs1_val !== 32'h9) begin failures++; $display("FAIL bypass_with_rename got=%0h/%0h exp=1/9", rs1_rdy, rs1_val); end
        tick(); idle();
        is_rs1 = 5'd4; #1;
        checks++; if (rs1_rdy !== 1'b0 || rs1_tag !== 4'd6) begin failures++; $display("FAIL rename_beats_clear got=%0h/%0h exp=0/6", rs1_rdy, rs1_tag); end
    endtask

    task automatic test_flush();
        tick(); idle(); do_rename(5'd7, 4'd3);
        tick(); idle();
        flush = 1'b1; do_commit(5'd9, 4'd0, 32'h11); do_rename(5'd8, 4'd4);
        tick(); idle();
        is_rs1 = 5'd7; is_rs2 = 5'd9; #1;
        checks++; if (rs1_rdy !== 1'b1 || rs1_val !== 32'h0) begin failures++; $display("FAIL flush_x7 got=%0h/%0h exp=1/0", rs1_rdy, rs1_val); end
        checks++; if (rs2_rdy !== 1'b1 || rs2_val !== 32'h11) begin failures++; $display("FAIL flush_commit_x9 got=%0h/%0h exp=1/11", rs2_rdy, rs2_val); end
        is_rs1 = 5'd4; is_rs2 = 5'd8; #1;
        checks++; if (rs1_rdy !== 1'b1 || rs1_val !== 32'h9) begin failures++; $display("FAIL flush_x4 got=%0h/%0h exp=1/9", rs1_rdy, rs1_val); end
        checks++; if (rs2_rdy !== 1'b1 || rs2_val !== 32'h0) begin failures++; $display("FAIL flush_beats_rename got=%0h/%0h exp=1/0", rs2_rdy, rs2_val); end
    endtask

    task automatic test_hold();
        tick(); idle(); do_rename(5'd12, 4'd8);
        tick(); idle();
        rdy = 1'b0; flush = 1'b1; do_rename(5'd10, 4'd7); do_commit(5'd9, 4'd0, 32'hFF);
        tick(); idle();
        is_rs1 = 5'd10; is_rs2 = 5'd9; #1;
        checks++; if (rs1_rdy !== 1'b1 || rs1_val !== 32'h0) begin failures++; $display("FAIL hold_rename got=%0h/%0h exp=1/0", rs1_rdy, rs1_val); end
        checks++; if (rs2_rdy !== 1'b1 || rs2_val !== 32'h11) begin failures++; $display("FAIL hold_commit got=%0h/%0h exp=1/11", rs2_rdy, rs2_val); end
        is_rs1 = 5'd12; #1;
        checks++; if (rs1_rdy !== 1'b0 || rs1_tag !== 4'd8) begin failures++; $display("FAIL hold_flush got=%0h/%0h exp=0/8", rs1_rdy, rs1_tag); end
    endtask

    task automatic test_x0();
        tick(); idle();
        do_rename(5'd0, 4'd9); do_commit(5'd0, 4'd0, 32'hDEAD);
        tick(); idle();
        is_rs1 = 5'd0; is_rs2 = 5'd0; #1;
        checks++; if (rs1_rdy !== 1'b1 || rs1_val !== 32'h0) begin failures++; $display("FAIL x0_read got=%0h/%0h exp=1/0", rs1_rdy, rs1_val); end
        checks++; if (rob_ord2 !== 4'd0) begin failures++; $display("FAIL x0_tag got=%0h exp=0", rob_ord2); end
    endtask

    task automatic test_back_to_back();
        tick(); idle(); do_rename(5'd13, 4'd15);
        tick(); idle(); do_commit(5'd13, 4'd15, 32'h123); do_rename(5'd14, 4'd0);
        tick(); idle();
        is_rs1 = 5'd13; is_rs2 = 5'd14; #1;
        checks++; if (rs1_rdy !== 1'b1 || rs1_val !== 32'h123) begin failures++; $display("FAIL b2b_commit got=%0h/%0h exp=1/123", rs1_rdy, rs1_val); end
        checks++; if (rs2_rdy !== 1'b0 || rs2_tag !== 4'd0) begin failures++; $display("FAIL b2b_rename got=%0h/%0h exp=0/0", rs2_rdy, rs2_tag); end
    endtask

    task automatic test_mid_reset();
        tick(); idle();
        rst = 1'b1; rdy = 1'b0; do_rename(5'd15, 4'd2); do_commit(5'd16, 4'd0, 32'h77);
        tick(); idle(); rst = 1'b0;
        is_rs1 = 5'd9; is_rs2 = 5'd12; #1;
        checks++; if (rs1_rdy !== 1'b1 || rs1_val !== 32'h0) begin failures++; $display("FAIL mid_reset_val got=%0h/%0h exp=1/0", rs1_rdy, rs1_val); end
        checks++; if (rs2_rdy !== 1'b1 || rs2_val !== 32'h0) begin failures++; $display("FAIL mid_reset_busy got=%0h/%0h exp=1/0", rs2_rdy, rs2_val); end
        is_rs1 = 5'd15; is_rs2 = 5'd16; #1;
        checks++; if (rs1_rdy !== 1'b1 || rs2_val !== 32'h0) begin failures++; $display("FAIL mid_reset_ignored got=%0h/%0h exp=1/0", rs1_rdy, rs2_val); end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_rename_rob();
        test_commit_bypass();
        test_newer_rename();
        test_flush();
        test_hold();
        test_x0();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
